serial_tx_frame: RTL and testbench

Parallel-in, serial-out frame transmitter that drives a single-bit data line for a downstream flip-flop-based serial receiver. Accepts a DATA_WIDTH-bit word on a load strobe, then emits a start bit (0), the data bits LSB first, and a stop bit (1). Each bit is held for CLKS_PER_BIT clocks, so a receiver sampling mid-bit captures stable data. It is the transmit end of the lab serial link and pairs with the shift-register receiver on the same line.

---
 rtl/serial_tx_frame_if.sv | 27 ++
 rtl/serial_tx_frame.sv | 148 ++++++++++++++
 tb/tb_serial_tx_frame.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_tx_frame_if.sv
// Parallel load / serial line bundle for the frame transmitter.
// The master drives the load strobe and payload; the slave (transmitter) drives the line and status.
interface serial_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  load;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  serial_out;
    logic                  busy;
    logic                  done;

    modport master (
        output load,
        output data_in,
        input  serial_out,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  data_in,
        output serial_out,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_tx_frame.sv
// Parallel-in, serial-out frame transmitter: start bit 0, DATA_WIDTH bits LSB first, stop bit 1,
// each bit held CLKS_PER_BIT clocks. All outputs come straight from flops.
module serial_tx_frame #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clock,
    input  logic             reset_b,
    serial_tx_frame_if.slave bus
);
    localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  serial_q, serial_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  bit_end;
    logic [DATA_WIDTH-1:0] shift_shr;

    assign bit_end   = (tick_q == TICK_LAST);
    assign shift_shr = shift_q >> 1;

    // NOTE: every register, including the shift register, sits on the async reset so an
    // abandoned frame leaves no stale payload behind.
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples pre-edge values.
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // The outputs are computed one step ahead so that they land in flops with the state.
    always_comb begin
        // NOTE: defaults first; every path then assigns every signal and no latch is inferred.
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (bus.load) begin
                    shift_d  = bus.data_in;
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = S_START;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) begin
                    tick_d   = '0;
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = shift_shr;
                    if (bit_q == BIT_LAST) begin
                        bit_d    = '0;
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_d    = bit_q + BIT_ONE;
                        serial_d = shift_shr[0];
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    tick_d   = '0;
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            default: begin
                state_d  = S_IDLE;
                tick_d   = '0;
                bit_d    = '0;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign bus.serial_out = serial_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

    busy_done_exclusive: assert property (
        @(posedge clock) disable iff (!reset_b) !(busy_q && done_q)
    );

    idle_line_high: assert property (
        @(posedge clock) disable iff (!reset_b) (!busy_q |-> serial_q)
    );
endmodule

// File: tb/tb_serial_tx_frame.sv
// Bench for serial_tx_frame: a default instance (8 bits, 4 clocks/bit) and a fast one
// (4 bits, 1 clock/bit), checked against a frame-timing model and a mid-bit sampling receiver.
module tb_serial_tx_frame;
    localparam int W   = 8;
    localparam int C   = 4;
    localparam int LEN = (W + 2) * C;
    localparam int FW  = 4;
    localparam int FC  = 1;
    localparam int FLEN = (FW + 2) * FC;

    logic clock;
    logic reset_b;
    int   checks;
    int   failures;

    serial_tx_frame_if #(.DATA_WIDTH(W))  bus_main ();
    serial_tx_frame_if #(.DATA_WIDTH(FW)) bus_fast ();

    serial_tx_frame #(.DATA_WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clock  (clock),
        .reset_b(reset_b),
        .bus    (bus_main)
    );

    serial_tx_frame #(.DATA_WIDTH(FW), .CLKS_PER_BIT(FC)) dut_fast (
        .clock  (clock),
        .reset_b(reset_b),
        .bus    (bus_fast)
    );

    logic [2:0] obs_m;
    logic [2:0] obs_f;
    assign obs_m = {bus_main.serial_out, bus_main.busy, bus_main.done};
    assign obs_f = {bus_fast.serial_out, bus_fast.busy, bus_fast.done};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected {serial_out, busy, done} t cycles after the accepting edge of a frame.
    function automatic logic [2:0] exp_line(input logic [63:0] word, input int w, input int c,
                                            input int t);
        int   len;
        int   n;
        logic s;
        len = (w + 2) * c;
        if (t < len) begin
            n = t / c;
            if (n == 0)      s = 1'b0;
            else if (n <= w) s = word[n-1];
            else             s = 1'b1;
            return {s, 1'b1, 1'b0};
        end
        if (t == len) return 3'b101;
        return 3'b100;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        bus_main.load = 1'b1;
        bus_fast.load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_main.data_in = W'($urandom);
            bus_fast.data_in = FW'($urandom);
            tick();
            checks++;
            if (obs_m !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold_main cycle=%0d got=%b exp=100", i, obs_m);
            end
            checks++;
            if (obs_f !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold_fast cycle=%0d got=%b exp=100", i, obs_f);
            end
        end
        bus_main.load = 1'b0;
        bus_fast.load = 1'b0;
        reset_b = 1'b1;
        repeat (2) tick();
        checks++;
        if (obs_m !== 3'b100) begin
            failures++;
            $display("FAIL reset_release got=%b exp=100", obs_m);
        end
    endtask

    task automatic test_single_frame();
        int seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [2:0] e;
        bus_main.data_in = 8'hA5;
        bus_main.load = 1'b1;
        tick();
        bus_main.load = 1'b0;
        for (int t = 0; t <= LEN + 4; t++) begin
            if (t > 0) begin
                bus_main.data_in = W'($urandom);
                tick();
            end
            e = exp_line(64'hA5, W, C, t);
            checks++;
            if (obs_m !== e) begin
                failures++;
                $display("FAIL single_frame t=%0d got=%b exp=%b", t, obs_m, e);
            end
            if (t < LEN && (t % C) == C / 2) begin
                checks++;
                if (obs_m[2] !== 1'(seq[t / C])) begin
                    failures++;
                    $display("FAIL single_frame_bit n=%0d got=%b exp=%0d", t / C, obs_m[2], seq[t / C]);
                end
            end
        end
    endtask

    task automatic test_load_while_busy();
        int seq [10] = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1};
        logic [2:0] e;
        bus_main.data_in = 8'h3C;
        bus_main.load = 1'b1;
        tick();
        bus_main.load = 1'b0;
        for (int t = 0; t <= 60; t++) begin
            if (t > 0) begin
                bus_main.load    = (t == 10);
                bus_main.data_in = (t == 10) ? 8'hFF : W'($urandom);
                tick();
            end
            e = exp_line(64'h3C, W, C, t);
            checks++;
            if (obs_m !== e) begin
                failures++;
                $display("FAIL load_while_busy t=%0d got=%b exp=%b", t, obs_m, e);
            end
            if (t < LEN && (t % C) == C / 2) begin
                checks++;
                if (obs_m[2] !== 1'(seq[t / C])) begin
                    failures++;
                    $display("FAIL load_while_busy_bit n=%0d got=%b exp=%0d", t / C, obs_m[2], seq[t / C]);
                end
            end
        end
        bus_main.load = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [2:0] e;
        int dones;
        dones = 0;
        bus_main.load = 1'b1;
        bus_main.data_in = words[0];
        for (int f = 0; f < 4; f++) begin
            for (int p = 0; p <= LEN; p++) begin
                tick();
                if (p == 0) begin
                    bus_main.data_in = words[(f + 1) % 4];
                    if (f == 3) bus_main.load = 1'b0;
                end
                e = exp_line(64'(words[f]), W, C, p);
                if (obs_m[0] === 1'b1) dones++;
                checks++;
                if (obs_m !== e) begin
                    failures++;
                    $display("FAIL back_to_back f=%0d p=%0d got=%b exp=%b", f, p, obs_m, e);
                end
            end
        end
        repeat (3) begin
            tick();
            if (obs_m[0] === 1'b1) dones++;
            checks++;
            if (obs_m !== 3'b100) begin
                failures++;
                $display("FAIL back_to_back_tail got=%b exp=100", obs_m);
            end
        end
        checks++;
        if (dones != 4) begin
            failures++;
            $display("FAIL back_to_back_done_count got=%0d exp=4", dones);
        end
    endtask

    task automatic test_fast_bits();
        int seq [6] = '{0, 1, 0, 0, 1, 1};
        logic [FW-1:0] word;
        logic [2:0] e;
        for (int i = 0; i < 5; i++) begin
            word = (i == 0) ? 4'b1001 : FW'($urandom);
            bus_fast.data_in = word;
            bus_fast.load = 1'b1;
            tick();
            bus_fast.load = 1'b0;
            for (int t = 0; t <= FLEN + 1; t++) begin
                if (t > 0) begin
                    bus_fast.data_in = FW'($urandom);
                    tick();
                end
                e = exp_line(64'(word), FW, FC, t);
                checks++;
                if (obs_f !== e) begin
                    failures++;
                    $display("FAIL fast_frame i=%0d t=%0d got=%b exp=%b", i, t, obs_f, e);
                end
                if (i == 0 && t < 6) begin
                    checks++;
                    if (obs_f[2] !== 1'(seq[t])) begin
                        failures++;
                        $display("FAIL fast_bit t=%0d got=%b exp=%0d", t, obs_f[2], seq[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        bus_main.data_in = 8'h00;
        bus_main.load = 1'b1;
        bus_fast.data_in = 4'h0;
        bus_fast.load = 1'b1;
        tick();
        bus_main.load = 1'b0;
        bus_fast.load = 1'b0;
        repeat (10) tick();
        checks++;
        if (obs_m !== 3'b010) begin
            failures++;
            $display("FAIL async_reset_pre got=%b exp=010", obs_m);
        end
        #2;
        reset_b = 1'b0;
        #1;
        checks++;
        if (obs_m !== 3'b100) begin
            failures++;
            $display("FAIL async_reset_immediate got=%b exp=100", obs_m);
        end
        repeat (2) begin
            tick();
            if (obs_m[0] === 1'b1) dones++;
        end
        reset_b = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (obs_m[0] === 1'b1) dones++;
            checks++;
            if (obs_m !== 3'b100) begin
                failures++;
                $display("FAIL async_reset_after cycle=%0d got=%b exp=100", i, obs_m);
            end
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL async_reset_no_done got=%0d exp=0", dones);
        end
    endtask

    task automatic test_loopback();
        logic [W-1:0] word;
        logic [W-1:0] rx;
        logic         framing_ok;
        int           n;
        for (int i = 0; i < 16; i++) begin
            word = W'($urandom);
            rx = '0;
            framing_ok = 1'b1;
            bus_main.data_in = word;
            bus_main.load = 1'b1;
            tick();
            bus_main.load = 1'b0;
            for (int t = 0; t < LEN; t++) begin
                if (t > 0) tick();
                if ((t % C) == C / 2) begin
                    n = t / C;
                    if (n == 0 && bus_main.serial_out !== 1'b0) framing_ok = 1'b0;
                    else if (n == W + 1 && bus_main.serial_out !== 1'b1) framing_ok = 1'b0;
                    else if (n >= 1 && n <= W) rx = {bus_main.serial_out, rx[W-1:1]};
                end
            end
            tick();
            checks++;
            if (rx !== word || !framing_ok) begin
                failures++;
                $display("FAIL loopback i=%0d got=%h framing=%b exp=%h", i, rx, framing_ok, word);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_b  = 1'b0;
        bus_main.load    = 1'b0;
        bus_main.data_in = '0;
        bus_fast.load    = 1'b0;
        bus_fast.data_in = '0;
        #3;
        test_reset();
        test_single_frame();
        test_load_while_busy();
        test_back_to_back();
        test_fast_bits();
        test_async_reset();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
